// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NUM_REQ requesters,
// with per-transfer timeout so a hung slave cannot lock out the other agents.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           rsp_timeout,
  output logic [1:0]                     transfer,
  output logic [ADDR_WIDTH-1:0]          address,
  output logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           apb_done,
  input  logic                           apb_err,
  input  logic [DATA_WIDTH-1:0]          apb_rdata,
  output logic                           busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] XFER_IDLE  = 2'b00;
  localparam logic [1:0] XFER_READ  = 2'b01;
  localparam logic [1:0] XFER_WRITE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] win_c;
  logic             any_c;
  logic [CNT_W-1:0] cnt;
  logic             expire_c;

  // Round-robin pick: first requester at or after last+1, wrapping.
  always_comb begin : rr_pick
    int unsigned idx;
    any_c = 1'b0;
    win_c = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!any_c && req[IDX_W'(idx)]) begin
        any_c = 1'b1;
        win_c = IDX_W'(idx);
      end
    end
  end

  // cnt counts completed WAIT cycles; abort on the WAIT cycle after TIMEOUT of them.
  assign expire_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= S_IDLE;
      last        <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      cnt         <= '0;
      gnt         <= '0;
      ack         <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      transfer    <= XFER_IDLE;
      address     <= '0;
      write_data  <= '0;
      busy        <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state)
        S_IDLE: begin
          if (any_c) begin
            owner      <= win_c;
            gnt        <= NUM_REQ'(1) << win_c;
            transfer   <= req_write[win_c] ? XFER_WRITE : XFER_READ;
            address    <= req_addr[win_c*ADDR_WIDTH +: ADDR_WIDTH];
            write_data <= req_wdata[win_c*DATA_WIDTH +: DATA_WIDTH];
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A completion in the expiry cycle takes priority over the abort.
          if (apb_done || expire_c) begin
            ack         <= NUM_REQ'(1) << owner;
            transfer    <= XFER_IDLE;
            rsp_err     <= apb_done ? apb_err : 1'b1;
            rsp_timeout <= !apb_done;
            rsp_rdata   <= (apb_done && transfer == XFER_READ) ? apb_rdata : '0;
            state       <= S_RESP;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          last        <= owner;
          gnt         <= '0;
          busy        <= 1'b0;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: rounds of requests are ordered by a round-robin model,
// an APB slave model answers each access, and a monitor checks every grant and acknowledge.
module tb_apb_req_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  typedef struct {
    int            done_cyc;   // WAIT cycle (1-based) carrying apb_done; 0 = never
    logic          err;
    logic [DW-1:0] rdata;
  } plan_t;

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            lat;        // cycles from transfer rising to ack
  } exp_t;

  logic              PCLK;
  logic              PRESET;
  logic [N-1:0]      req;
  logic [N-1:0]      wr_v;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      gnt;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [1:0]        transfer;
  logic [AW-1:0]     address;
  logic [DW-1:0]     write_data;
  logic              apb_done;
  logic              apb_err;
  logic [DW-1:0]     apb_rdata;
  logic              busy;

  logic [AW-1:0]     addr_a  [N];
  logic [DW-1:0]     wdata_a [N];

  logic [N-1:0]      st_set;
  logic              st_wr    [N];
  logic [AW-1:0]     st_addr  [N];
  logic [DW-1:0]     st_wdata [N];
  plan_t             st_plan  [N];

  exp_t  exp_q  [$];
  plan_t plan_q [$];
  exp_t  cur;
  int    checks = 0;
  int    errors = 0;
  int    acks_seen = 0;
  int    model_last = N - 1;
  int    mcyc = 0;
  int    t0 = 0;
  bit    in_flight = 0;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(wr_v),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .transfer(transfer), .address(address), .write_data(write_data),
    .apb_done(apb_done), .apb_err(apb_err), .apb_rdata(apb_rdata), .busy(busy)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_a[i];
      req_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // APB slave: raises apb_done in the planned WAIT cycle of each access.
  initial begin : slave
    int    k;
    plan_t p;
    k = 0;
    p = '{done_cyc: 1, err: 1'b0, rdata: '0};
    apb_done = 1'b0; apb_err = 1'b0; apb_rdata = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESET && transfer != 2'b00) begin
        if (k == 0 && plan_q.size() > 0) p = plan_q.pop_front();
        k++;
        apb_done  = (k == p.done_cyc);
        apb_err   = apb_done & p.err;
        apb_rdata = $urandom;
        if (apb_done) apb_rdata = p.rdata;
      end else begin
        k = 0;
        apb_done = 1'b0;
        apb_err  = 1'b0;
      end
    end
  end

  // Monitor: pops the expected transaction when a transfer starts, checks it at ack.
  initial begin : monitor
    logic [1:0] prev_tr;
    prev_tr = 2'b00;
    forever begin
      @(negedge PCLK);
      mcyc++;
      if (PRESET) begin
        in_flight = 0;
        prev_tr   = 2'b00;
      end else begin
        if (transfer != 2'b00 && prev_tr == 2'b00) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_transfer: got transfer %0b gnt %0b, expected none", transfer, gnt);
          end else begin
            cur = exp_q.pop_front();
            in_flight = 1;
            t0 = mcyc;
            chk("xfer_type", transfer, cur.wr ? 2'b10 : 2'b01);
            chk("xfer_addr", address, cur.addr);
            chk("xfer_wdata", write_data, cur.wdata);
            chk("xfer_gnt", gnt, onehot(cur.idx));
            chk("xfer_busy", busy, 1'b1);
          end
        end
        if (ack != '0) begin
          acks_seen++;
          if (!in_flight) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack %0b, expected none", ack);
          end else begin
            chk("ack_onehot", ack, onehot(cur.idx));
            chk("ack_gnt", gnt, onehot(cur.idx));
            chk("ack_rdata", rsp_rdata, cur.rdata);
            chk("ack_err", rsp_err, cur.err);
            chk("ack_timeout", rsp_timeout, cur.tmo);
            chk("ack_transfer", transfer, 2'b00);
            chk("ack_latency", mcyc - t0, cur.lat);
            in_flight = 0;
          end
        end
        prev_tr = transfer;
      end
    end
  end

  task automatic stage(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dc, input logic e, input logic [DW-1:0] rd);
    st_set[i]   = 1'b1;
    st_wr[i]    = w;
    st_addr[i]  = a;
    st_wdata[i] = d;
    st_plan[i]  = '{done_cyc: dc, err: e, rdata: rd};
  endtask

  // Reference model: staged requesters are served in cyclic order after the last winner.
  task automatic prep(output int n);
    exp_t e;
    int   i;
    int   last_i;
    bit   tmo;
    n = 0;
    last_i = model_last;
    for (int k = 1; k <= N; k++) begin
      i = (model_last + k) % N;
      if (st_set[i]) begin
        tmo     = (st_plan[i].done_cyc == 0) || (st_plan[i].done_cyc > T + 1);
        e.idx   = i;
        e.wr    = st_wr[i];
        e.addr  = st_addr[i];
        e.wdata = st_wdata[i];
        e.tmo   = tmo;
        e.err   = tmo ? 1'b1 : st_plan[i].err;
        e.rdata = (tmo || st_wr[i]) ? '0 : st_plan[i].rdata;
        e.lat   = tmo ? T + 1 : st_plan[i].done_cyc;
        exp_q.push_back(e);
        plan_q.push_back(st_plan[i]);
        last_i = i;
        n++;
      end
    end
    model_last = last_i;
  endtask

  task automatic launch();
    @(negedge PCLK);
    for (int i = 0; i < N; i++) begin
      if (st_set[i]) begin
        addr_a[i]  = st_addr[i];
        wdata_a[i] = st_wdata[i];
        wr_v[i]    = st_wr[i];
      end
    end
    req = st_set;
  endtask

  // mode 0: plain; 1: req2 pulses while another transfer is in WAIT; 2: drop req once granted.
  task automatic go(input int mode);
    int n;
    int cyc;
    int target;
    prep(n);
    target = acks_seen + n;
    launch();
    cyc = 0;
    while (acks_seen < target) begin
      @(negedge PCLK);
      cyc++;
      if (cyc > 60 * n + 20) begin
        checks++; errors++;
        $display("FAIL round_budget: got %0d acks, expected %0d", acks_seen, target);
        finish_sim();
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        if (gnt[i]) begin
          addr_a[i]  = $urandom;
          wdata_a[i] = $urandom;
          wr_v[i]    = 1'($urandom);
        end
      end
      if (mode == 2 && gnt != '0) req = req & ~gnt;
      if (mode == 1 && cyc == 3) req[2] = 1'b1;
      if (mode == 1 && cyc == 5) req[2] = 1'b0;
    end
    st_set = '0;
  endtask

  function automatic int pick_dc();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return T + 1;
    if (r == 2) return T + 2;
    return r - 2;
  endfunction

  initial begin : driver
    int n;
    int w;
    logic [N-1:0] set;
    PRESET = 1'b1;
    req = '0; wr_v = '0; st_set = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0; wdata_a[i] = '0;
    end
    repeat (2) @(negedge PCLK);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_transfer", transfer, 0);
    chk("rst_busy", busy, 0);
    chk("rst_address", address, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Contention straight after reset: 0 then 1, twice.
    repeat (2) begin
      stage(0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 1, 1'b0, $urandom);
      stage(1, 1'b0, 32'h0000_2000, $urandom, 2, 1'b0, 32'h1234_5678);
      go(0);
    end
    // Single read with one wait state.
    stage(0, 1'b0, 32'h0000_1004, $urandom, 3, 1'b0, 32'hDEAD_BEEF);
    go(0);
    // Slave error on a write.
    stage(1, 1'b1, 32'h0000_2008, $urandom, 2, 1'b1, $urandom);
    go(0);
    // Timeout, then a waiting requester served normally.
    stage(0, 1'b0, 32'h0000_3000, $urandom, 0, 1'b0, $urandom);
    stage(1, 1'b0, 32'h0000_3004, $urandom, 1, 1'b0, 32'hCAFE_0001);
    go(0);
    // Done in the last WAIT cycles before the abort.
    stage(2, 1'b0, 32'h0000_4000, $urandom, T + 1, 1'b0, 32'h600D_600D);
    go(0);
    stage(2, 1'b1, 32'h0000_4004, $urandom, T, 1'b1, $urandom);
    go(0);
    // Request pulsed and withdrawn while another is served: ignored.
    stage(0, 1'b0, 32'h0000_5000, $urandom, 6, 1'b0, 32'h1111_2222);
    go(1);
    // Request withdrawn after grant still completes.
    stage(1, 1'b0, 32'h0000_6000, $urandom, 4, 1'b0, 32'h3333_4444);
    go(2);

    repeat (40) begin
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (set[i]) stage(i, 1'($urandom), $urandom, $urandom, pick_dc(), ($urandom % 4) == 0, $urandom);
      go(0);
    end

    // Reset in the middle of WAIT: everything clears at once, no ack.
    stage(0, 1'b0, 32'h0000_7000, $urandom, 0, 1'b0, $urandom);
    prep(n);
    launch();
    w = 0;
    while (transfer == 2'b00) begin
      @(negedge PCLK);
      w++;
      if (w > 10) begin
        checks++; errors++;
        $display("FAIL reset_wait: got transfer %0b, expected nonzero", transfer);
        finish_sim();
      end
    end
    repeat (2) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("mid_rst_transfer", transfer, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    exp_q.delete();
    plan_q.delete();
    req = '0;
    st_set = '0;
    model_last = N - 1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    stage(1, 1'b0, 32'h0000_8004, $urandom, 2, 1'b0, 32'h5555_6666);
    stage(0, 1'b1, 32'h0000_8000, 32'h7777_8888, 1, 1'b0, $urandom);
    go(0);
    stage(1, 1'b0, 32'h0000_8008, $urandom, 1, 1'b0, 32'h9999_AAAA);
    go(0);

    repeat (4) @(negedge PCLK);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("plan_q_drained", plan_q.size(), 0);
    chk("idle_busy", busy, 0);
    finish_sim();
  end

endmodule
